blinkpat_decoder: RTL and testbench
===================================

// Module: blinkpat_decoder
// PURPOSE
//  Receive side of the 8-step LED blink protocol. Samples a 3-bit LED bus (pins or loopback)
//  once per step, locks to the frame sync (000 then 001), then checks steps 2..7 against
//  pattern A (colpat=0) and pattern B (colpat=1). Reports which pattern is running, and
//  flags corrupt frames. Used for board self-test and for a second board watching the first.
// PARAMETERS
//  STEP_CYCLES    67108864  CLK cycles per pattern step (2**26, matches the transmitter divider)
//  SAMPLE_OFFSET  33554432  phase count at which a step is sampled (mid-step); must be < STEP_CYCLES
// PORTS
//  CLK        in   1  system clock; the only clock
//  RST        in   1  synchronous reset, active-high
//  LED_IN     in   3  observed LED bus, async to CLK; bit2 = MSB of the step symbol
//  LOCKED     out  1  1 = at least one good frame seen, and no error since
//  PAT_ID     out  1  pattern of the last good frame: 0 = A, 1 = B
//  FRAME_OK   out  1  one-cycle pulse: a frame of steps 0..7 matched A or B
//  FRAME_ERR  out  1  one-cycle pulse: a frame failed while synced (rules below)
//  STEP_IDX   out  3  index of the step the FSM expects next (0 while in HUNT)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, phase=0, synchronizer=000, match flags=1.
//   RST wins over everything on the same edge, including mid-frame.
//  Input: 2-FF synchronizer per bit, then one more register. "edge" = registered value != synced value.
//  Phase counter: width clog2(STEP_CYCLES).
//   - Cleared to 0 on edge.
//   - Otherwise increments and wraps STEP_CYCLES-1 -> 0.
//   - Free-runs when the input is static, so a constant symbol is sampled once per step.
//  sample strobe: phase==SAMPLE_OFFSET. The FSM acts only on a strobe. sym = synced value at the strobe.
//  Symbol tables, steps 2..7:
//   A = 010,011,100,101,110,111
//   B = 011,010,110,111,101,100
//  FSM states: HUNT, S0, S1, CHK (CHK uses STEP_IDX 2..7).
//   HUNT: sym==000 -> S1.
//   S1:   sym==001 -> CHK, step=2, matchA=matchB=1.
//         sym==000 -> stay in S1.
//         other, LOCKED=0 -> HUNT, no error.
//         other, LOCKED=1 -> FRAME_ERR, HUNT.
//   CHK:  matchA &= (sym==A[step]); matchB &= (sym==B[step]). Uses the new values.
//         both cleared at any step -> FRAME_ERR, LOCKED<=0, HUNT (no waiting for step 7).
//         step<7 -> step+1.
//         step==7 and still matched -> FRAME_OK, PAT_ID<=~matchA (A wins if both), LOCKED<=1, S0.
//   S0:   sym==000 -> S1.
//         else -> FRAME_ERR, LOCKED<=0, HUNT.
//  FRAME_OK and FRAME_ERR are registered. They assert on the edge after the deciding strobe,
//   for exactly 1 cycle, and are never high together.
//  Frame latency: FRAME_OK rises 1 cycle after the step-7 strobe.
//  Pattern switch on a frame boundary: the next frame gives FRAME_OK with the new PAT_ID.
//   LOCKED stays 1.
//  Pattern switch mid-frame: mixed symbols -> FRAME_ERR at the first step that matches neither.
//  PAT_ID holds its value through errors and HUNT. Only a FRAME_OK changes it.
// TESTING (STEP_CYCLES=8, SAMPLE_OFFSET=4; LED_IN driven in 8-cycle steps)
//  T1: reset, then pattern A frames x3
//      -> FRAME_OK x3, PAT_ID=0, LOCKED=1 after the first, FRAME_ERR never.
//  T2: A frame, then B frames on a frame boundary
//      -> 2nd FRAME_OK has PAT_ID=1, LOCKED stays 1, no FRAME_ERR.
//  T3: locked on A; step 4 driven 110 instead of 100
//      -> FRAME_ERR pulse 1 cycle after that strobe, LOCKED=0, STEP_IDX=0.
//      Next clean frame -> FRAME_OK, LOCKED=1.
//  T4: unlocked; LED_IN 000, 101, 000, 001, then A
//      -> no FRAME_ERR during hunting, one FRAME_OK at the end of the A frame.
//  T5: locked; RST high for 1 cycle at step 5
//      -> all outputs 0 next cycle. The remaining partial frame yields no pulse.
//      The following full frame -> FRAME_OK.
//  T6: locked on B; step 7 held 8 extra cycles (frame stretched)
//      -> S0 samples 100 -> FRAME_ERR, LOCKED=0.

Source files
------------

// File: rtl/blinkpat_decoder.sv
// ---------------------------------------------------------------------------
// blinkpat_decoder
//   Receive side of the 8-step LED blink protocol. The 3-bit LED bus is
//   resynchronised, sampled once per step at mid-step, locked to the frame
//   sync (000 then 001), and steps 2..7 are checked against pattern A and
//   pattern B in parallel. Reports the running pattern and flags corrupt
//   frames.
//
// Parameters
//   STEP_CYCLES    CLK cycles per pattern step (matches transmitter divider)
//   SAMPLE_OFFSET  phase count at which a step is sampled; < STEP_CYCLES
//
// Ports
//   CLK        in   1  system clock
//   RST        in   1  synchronous reset, active-high
//   LED_IN     in   3  observed LED bus, asynchronous to CLK
//   LOCKED     out  1  good frame seen and no error since
//   PAT_ID     out  1  pattern of the last good frame (0 = A, 1 = B)
//   FRAME_OK   out  1  one-cycle pulse: frame matched A or B
//   FRAME_ERR  out  1  one-cycle pulse: frame failed while synced
//   STEP_IDX   out  3  step the FSM expects next (0 in HUNT)
// ---------------------------------------------------------------------------
module blinkpat_decoder #(
  parameter int STEP_CYCLES   = 67108864,
  parameter int SAMPLE_OFFSET = 33554432
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] LED_IN,
  output logic       LOCKED,
  output logic       PAT_ID,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [2:0] STEP_IDX
);

  localparam int            PW           = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_OFFSET);

  typedef enum logic [1:0] {HUNT, S0, S1, CHK} state_t;

  // Pattern A simply counts up through steps 2..7.
  function automatic logic [2:0] sym_a(input logic [2:0] step);
    return step;
  endfunction

  function automatic logic [2:0] sym_b(input logic [2:0] step);
    case (step)
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b110;
      3'd5:    return 3'b111;
      3'd6:    return 3'b101;
      3'd7:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Input synchroniser, edge detect and step phase counter
  // -------------------------------------------------------------------------
  logic [2:0]    led_meta, led_sync, led_prev;
  logic [PW-1:0] phase;
  logic          led_edge;
  logic          strobe;

  assign led_edge = (led_prev != led_sync);
  assign strobe   = (phase == PHASE_SAMPLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_meta <= '0;
      led_sync <= '0;
      led_prev <= '0;
      phase    <= '0;
    end else begin
      led_meta <= LED_IN;
      led_sync <= led_meta;
      led_prev <= led_sync;
      // Any symbol change re-centres the sampling point; a static symbol
      // lets the counter free-run so it is still sampled once per step.
      if (led_edge || phase == PHASE_LAST) phase <= '0;
      else                                 phase <= phase + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       match_a_q, match_a_d, match_b_q, match_b_d;
  logic       locked_d, pat_d, ok_d, err_d;
  logic       hit_a, hit_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HUNT;
      step_q    <= '0;
      match_a_q <= 1'b1;
      match_b_q <= 1'b1;
      LOCKED    <= 1'b0;
      PAT_ID    <= 1'b0;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      match_a_q <= match_a_d;
      match_b_q <= match_b_d;
      LOCKED    <= locked_d;
      PAT_ID    <= pat_d;
      FRAME_OK  <= ok_d;
      FRAME_ERR <= err_d;
    end
  end

  // Running match flags including the symbol being sampled now.
  assign hit_a = match_a_q & (led_sync == sym_a(step_q));
  assign hit_b = match_b_q & (led_sync == sym_b(step_q));

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    match_a_d = match_a_q;
    match_b_d = match_b_q;
    locked_d  = LOCKED;
    pat_d     = PAT_ID;
    ok_d      = 1'b0;
    err_d     = 1'b0;

    if (strobe) begin
      case (state_q)
        HUNT: begin
          if (led_sync == 3'b000) state_d = S1;
        end
        S1: begin
          if (led_sync == 3'b001) begin
            state_d   = CHK;
            step_d    = 3'd2;
            match_a_d = 1'b1;
            match_b_d = 1'b1;
          end else if (led_sync != 3'b000) begin
            // Losing sync only counts as an error once we were locked.
            state_d  = HUNT;
            err_d    = LOCKED;
            locked_d = 1'b0;
          end
        end
        CHK: begin
          if (!hit_a && !hit_b) begin
            state_d  = HUNT;
            err_d    = 1'b1;
            locked_d = 1'b0;
          end else if (step_q == 3'd7) begin
            state_d  = S0;
            ok_d     = 1'b1;
            locked_d = 1'b1;
            pat_d    = ~hit_a;  // A wins when both still match
          end else begin
            step_d    = step_q + 3'd1;
            match_a_d = hit_a;
            match_b_d = hit_b;
          end
        end
        S0: begin
          if (led_sync == 3'b000) begin
            state_d = S1;
          end else begin
            state_d  = HUNT;
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    STEP_IDX = 3'd0;
    case (state_q)
      S1:      STEP_IDX = 3'd1;
      CHK:     STEP_IDX = step_q;
      default: STEP_IDX = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_blinkpat_decoder.sv
// ---------------------------------------------------------------------------
// tb_blinkpat_decoder
//   Directed bench for blinkpat_decoder with STEP_CYCLES=8, SAMPLE_OFFSET=4.
//   LED_IN is driven in 8-cycle steps; each vector holds one symbol for one
//   step and checks the pulses seen during that step plus the state at its
//   end. The decision for a step lands on the last negedge of its window.
// ---------------------------------------------------------------------------
module tb_blinkpat_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] LED_IN;
  logic       LOCKED, PAT_ID, FRAME_OK, FRAME_ERR;
  logic [2:0] STEP_IDX;

  always #5 CLK = ~CLK;

  blinkpat_decoder #(.STEP_CYCLES(8), .SAMPLE_OFFSET(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LED_IN   (LED_IN),
    .LOCKED   (LOCKED),
    .PAT_ID   (PAT_ID),
    .FRAME_OK (FRAME_OK),
    .FRAME_ERR(FRAME_ERR),
    .STEP_IDX (STEP_IDX)
  );

  typedef struct {
    bit         do_rst;   // reset + alignment step instead of a symbol
    logic [2:0] sym;
    bit         exp_ok;
    bit         exp_err;
    bit         exp_lk;
    bit         exp_pat;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t       vecs[$];
  int         split;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] pat_a[8];
  logic [2:0] pat_b[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---- vector construction -------------------------------------------------
  task automatic add_v(input logic [2:0] sym, input bit ok, input bit err,
                       input bit lk, input bit pat, input logic [2:0] idx);
    vec_t v;
    v.do_rst = 1'b0; v.sym = sym; v.exp_ok = ok; v.exp_err = err;
    v.exp_lk = lk; v.exp_pat = pat; v.exp_idx = idx;
    vecs.push_back(v);
  endtask

  task automatic add_reset();
    vec_t v;
    v.do_rst = 1'b1; v.sym = 3'b111; v.exp_ok = 0; v.exp_err = 0;
    v.exp_lk = 0; v.exp_pat = 0; v.exp_idx = 3'd0;
    vecs.push_back(v);
  endtask

  // Non-deciding steps first..last of a frame: after step s the FSM expects s+1.
  task automatic add_steps(input bit use_b, input int first, input int last,
                           input bit lk, input bit pat);
    for (int s = first; s <= last; s++)
      add_v(use_b ? pat_b[s] : pat_a[s], 1'b0, 1'b0, lk, pat, 3'(s + 1));
  endtask

  // Clean frame: steps 0..6 keep LOCKED/PAT_ID, step 7 gives FRAME_OK.
  task automatic add_frame(input bit use_b, input bit lk, input bit pat);
    add_steps(use_b, 0, 6, lk, pat);
    add_v(use_b ? pat_b[7] : pat_a[7], 1'b1, 1'b0, 1'b1, use_b, 3'd0);
  endtask

  // ---- stimulus application -----------------------------------------------
  task automatic run_window(output int ok_n, output int err_n, output int both_n,
                            output int pos);
    ok_n = 0; err_n = 0; both_n = 0; pos = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (FRAME_OK === 1'b1)  begin ok_n++;  pos = i; end
      if (FRAME_ERR === 1'b1) begin err_n++; pos = i; end
      if (FRAME_OK === 1'b1 && FRAME_ERR === 1'b1) both_n++;
    end
  endtask

  task automatic check_step(input string name, input vec_t v);
    int ok_n, err_n, both_n, pos;
    logic [13:0] act, exp;
    LED_IN = v.sym;
    run_window(ok_n, err_n, both_n, pos);
    act = {2'(ok_n), 2'(err_n), 1'(both_n), 4'(pos), LOCKED, PAT_ID, STEP_IDX};
    exp = {1'b0, v.exp_ok, 1'b0, v.exp_err, 1'b0,
           ((v.exp_ok || v.exp_err) ? 4'd8 : 4'd0),
           v.exp_lk, v.exp_pat, v.exp_idx};
    check($sformatf("%s sym=%b {ok,err,both,pos,lk,pat,idx}", name, v.sym),
          32'(act), 32'(exp));
  endtask

  // Reset, check the reset state, then hold 111 for one step so that the
  // symbol edge after release aligns the sampling phase.
  task automatic do_reset(input string name);
    vec_t v;
    LED_IN = 3'b111;
    RST    = 1'b1;
    repeat (2) @(negedge CLK);
    check({name, " reset state"},
          32'({LOCKED, PAT_ID, FRAME_OK, FRAME_ERR, STEP_IDX}), 32'd0);
    RST = 1'b0;
    v.do_rst = 1'b0; v.sym = 3'b111; v.exp_ok = 0; v.exp_err = 0;
    v.exp_lk = 0; v.exp_pat = 0; v.exp_idx = 3'd0;
    check_step({name, " align"}, v);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.do_rst) do_reset($sformatf("vec%0d", idx));
    else          check_step($sformatf("vec%0d", idx), v);
  endtask

  // ---- watchdog -------------------------------------------------------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---- main test ------------------------------------------------------------
  initial begin
    int pulses;
    RST    = 1'b1;
    LED_IN = 3'b111;
    pat_a  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    pat_b  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // T1: three A frames from reset.
    add_reset();
    add_frame(1'b0, 1'b0, 1'b0);
    add_frame(1'b0, 1'b1, 1'b0);
    add_frame(1'b0, 1'b1, 1'b0);
    // T2: switch to B on a frame boundary.
    add_frame(1'b1, 1'b1, 1'b0);
    add_frame(1'b1, 1'b1, 1'b1);
    // T3: lock on A, then corrupt step 4, then recover.
    add_frame(1'b0, 1'b1, 1'b1);
    add_steps(1'b0, 0, 3, 1'b1, 1'b0);
    add_v(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    add_v(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_v(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_v(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_frame(1'b0, 1'b0, 1'b0);
    // T4: unlocked false start 000,101 is dropped silently.
    add_reset();
    add_v(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add_v(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_v(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add_v(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    add_steps(1'b0, 2, 6, 1'b0, 1'b0);
    add_v(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    // Lead-in to T5: lock on B, then B steps 0..4.
    add_frame(1'b1, 1'b1, 1'b0);
    add_steps(1'b1, 0, 4, 1'b1, 1'b1);
    split = vecs.size();
    // T5 tail: rest of the broken frame is ignored, then a full B frame.
    add_v(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_v(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_frame(1'b1, 1'b0, 1'b0);
    // T6: B frame whose step 7 is held for a second step.
    add_steps(1'b1, 0, 6, 1'b1, 1'b1);
    add_v(3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    add_v(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    add_frame(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < split; i++) apply_vec(vecs[i], i);

    // T5: one-cycle reset in the middle of step 5 of a locked B frame.
    pulses = 0;
    LED_IN = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (FRAME_OK === 1'b1 || FRAME_ERR === 1'b1) pulses++;
      if (i == 3) begin
        check("T5 locked before reset", 32'({LOCKED, PAT_ID, STEP_IDX}), 32'({1'b1, 1'b1, 3'd5}));
        RST = 1'b1;
      end
      if (i == 4) begin
        check("T5 outputs after reset",
              32'({LOCKED, PAT_ID, FRAME_OK, FRAME_ERR, STEP_IDX}), 32'd0);
        RST = 1'b0;
      end
    end
    check("T5 pulses in reset step", 32'(pulses), 32'd0);

    for (int i = split; i < vecs.size(); i++) apply_vec(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
